// File: rtl/phy_pkg.sv
// Shared types and group geometry for the receive-side depuncturing path.
package phy_pkg;

  localparam int MAX_BITS_DEF = 288;

  typedef enum logic [1:0] {
    MODE_R12 = 2'd0,
    MODE_R34 = 2'd1,
    MODE_R23 = 2'd2
  } mode_e;

  typedef struct packed {
    logic b;
    logic a;
  } pair_t;

  // Mode code 3 is reserved and behaves like rate 1/2.
  function automatic mode_e to_mode(input logic [1:0] code);
    case (code)
      2'd1:    return MODE_R34;
      2'd2:    return MODE_R23;
      default: return MODE_R12;
    endcase
  endfunction

  function automatic logic [1:0] pairs_per_group(input mode_e m);
    case (m)
      MODE_R34: return 2'd3;
      MODE_R23: return 2'd2;
      default:  return 2'd1;
    endcase
  endfunction

  function automatic logic [2:0] bits_per_group(input mode_e m);
    case (m)
      MODE_R34: return 3'd4;
      MODE_R23: return 3'd3;
      default:  return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/s2p_bit_buffer.sv
// Circular single-bit buffer with a two-bit look-ahead read port and an
// occupancy count; the reader may consume 0, 1 or 2 bits per cycle.
module s2p_bit_buffer #(
  parameter int MAX_BITS = 288,
  localparam int PTR_W = $clog2(MAX_BITS),
  localparam int CNT_W = $clog2(MAX_BITS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_bit,
  input  logic [1:0]       rd_num,
  output logic             wr_accept,
  output logic [1:0]       rd_bits,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic             mem [MAX_BITS];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_1, rd_ptr_2;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_BITS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_ptr_1  = ptr_inc(rd_ptr_q);
  assign rd_ptr_2  = ptr_inc(rd_ptr_1);
  assign wr_accept = wr_en && (count_q != CNT_W'(MAX_BITS));
  assign rd_bits   = {mem[rd_ptr_1], mem[rd_ptr_q]};
  assign count     = count_q;
  assign empty     = (count_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) wr_ptr_d = ptr_inc(wr_ptr_q);
    case (rd_num)
      2'd1:    rd_ptr_d = rd_ptr_1;
      2'd2:    rd_ptr_d = rd_ptr_2;
      default: rd_ptr_d = rd_ptr_q;
    endcase
    count_d = count_q + CNT_W'(wr_accept) - CNT_W'(rd_num);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_ptr_q] <= wr_bit;
  end

endmodule

// File: rtl/depuncture_s2p.sv
// Serial-to-parallel depuncturer: buffers coded bits and emits {B,A} pairs,
// re-inserting a dummy bit wherever rate-3/4 or rate-2/3 puncturing removed one.
module depuncture_s2p
  import phy_pkg::*;
#(
  parameter int   MAX_BITS = MAX_BITS_DEF,
  parameter logic DUMMY    = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       data_in_valid,
  input  logic [1:0] mode,
  input  logic       read_en,
  output logic [1:0] data_out,
  output logic       data_out_valid
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);

  logic             wr_accept;
  logic [1:0]       rd_bits;
  logic [1:0]       rd_num;
  logic [CNT_W-1:0] count;
  logic             empty;

  mode_e      mode_q, mode_d;
  logic [1:0] phase_q, phase_d;
  pair_t      data_q, data_d;
  logic       valid_q, valid_d;

  logic [1:0] need;
  pair_t      pair;
  logic       fire;

  s2p_bit_buffer #(.MAX_BITS(MAX_BITS)) u_buf (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (data_in_valid),
    .wr_bit    (data_in),
    .rd_num    (rd_num),
    .wr_accept (wr_accept),
    .rd_bits   (rd_bits),
    .count     (count),
    .empty     (empty)
  );

  // Which bits the current group position needs and how the pair is formed.
  always_comb begin
    need   = 2'd2;
    pair.b = rd_bits[1];
    pair.a = rd_bits[0];
    if (phase_q != 2'd0) begin
      need = 2'd1;
      if (mode_q == MODE_R34 && phase_q == 2'd2) begin
        pair.b = rd_bits[0];
        pair.a = DUMMY;
      end else begin
        pair.b = DUMMY;
        pair.a = rd_bits[0];
      end
    end
  end

  assign fire   = read_en && (count >= CNT_W'(need));
  assign rd_num = fire ? need : 2'd0;

  // An empty buffer with the consumer idle ends the stream; an empty buffer
  // while read_en is high is starvation, which must keep the group position.
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    data_d  = data_q;
    valid_d = fire;
    if (wr_accept && empty && phase_q == 2'd0) mode_d = to_mode(mode);
    if (fire) begin
      data_d  = pair;
      phase_d = (phase_q == pairs_per_group(mode_q) - 2'd1) ? 2'd0 : phase_q + 2'd1;
    end else if (empty && !read_en) begin
      phase_d = 2'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_R12;
      phase_q <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;

endmodule

// File: tb/tb_depuncture_s2p.sv
// Randomized bench: expected pair streams are rebuilt from the written bits
// with the group mapping rules and compared against every emitted pair.
module tb_depuncture_s2p;

  localparam int MAX_BITS = 288;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b0;
  logic       data_in_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       read_en = 1'b0;
  logic [1:0] data_out;
  logic       data_out_valid;

  int vectors = 0;
  int errors  = 0;

  bit         tx_bits[$];
  logic [1:0] got[$];
  logic [1:0] exp_q[$];

  depuncture_s2p #(.MAX_BITS(MAX_BITS), .DUMMY(1'b0)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .mode           (mode),
    .read_en        (read_en),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (reset === 1'b1 && data_out_valid === 1'b1) got.push_back(data_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected {B,A} stream from the accepted bits; only whole groups are used.
  function automatic void build_expected(input int m, input int n_bits);
    exp_q.delete();
    case (m)
      1: for (int i = 0; i + 3 < n_bits; i += 4) begin
           exp_q.push_back({tx_bits[i+1], tx_bits[i]});
           exp_q.push_back({1'b0, tx_bits[i+2]});
           exp_q.push_back({tx_bits[i+3], 1'b0});
         end
      2: for (int i = 0; i + 2 < n_bits; i += 3) begin
           exp_q.push_back({tx_bits[i+1], tx_bits[i]});
           exp_q.push_back({1'b0, tx_bits[i+2]});
         end
      default: for (int i = 0; i + 1 < n_bits; i += 2)
           exp_q.push_back({tx_bits[i+1], tx_bits[i]});
    endcase
  endfunction

  function automatic void make_bits(input int n, input int prefix_kind);
    tx_bits.delete();
    for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom));
    if (prefix_kind == 1) begin
      tx_bits[0] = 1; tx_bits[1] = 1; tx_bits[2] = 0; tx_bits[3] = 1;
    end else if (prefix_kind == 2) begin
      tx_bits[0] = 1; tx_bits[1] = 0; tx_bits[2] = 1;
    end else if (prefix_kind == 3) begin
      tx_bits[0] = 1; tx_bits[1] = 0; tx_bits[2] = 1; tx_bits[3] = 1;
    end
  endfunction

  // After the first write the mode input is scrambled; the latch must ignore it.
  task automatic write_all(input logic [1:0] m, input int gap);
    mode = m;
    foreach (tx_bits[i]) begin
      data_in       = tx_bits[i];
      data_in_valid = 1'b1;
      step();
      if (!read_en) mode = 2'($urandom);
      data_in_valid = 1'b0;
      data_in       = 1'($urandom);
      for (int g = 0; g < gap; g++) step();
    end
    mode = m;
  endtask

  task automatic drain_and_compare(input string tag, input int budget);
    read_en = 1'b1;
    for (int c = 0; c < budget; c++) step();
    read_en = 1'b0;
    step();
    step();
    check({tag, " pairs"}, got.size(), exp_q.size());
    check({tag, " valid_end"}, data_out_valid, 1'b0);
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      check($sformatf("%s pair%0d", tag, k), got[k], exp_q[k]);
    got.delete();
  endtask

  initial begin
    // Reset held low with random activity.
    #1 reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      data_in = 1'($urandom); data_in_valid = 1'($urandom);
      mode = 2'($urandom);    read_en = 1'($urandom);
      @(negedge clock);
      check("rst valid", data_out_valid, 1'b0);
      check("rst data", data_out, 2'b00);
    end
    data_in_valid = 1'b0; read_en = 1'b0; mode = 2'd0;
    step();
    reset = 1'b1;
    step();
    got.delete();

    make_bits(96, 3);
    write_all(2'd0, 0);
    build_expected(0, 96);
    drain_and_compare("r12", 80);

    make_bits(96, 1);
    write_all(2'd1, 0);
    build_expected(1, 96);
    drain_and_compare("r34", 100);

    make_bits(96, 2);
    write_all(2'd2, 0);
    build_expected(2, 96);
    drain_and_compare("r23", 90);

    // Starved consumer: read_en high throughout, one bit every three clocks.
    make_bits(48, 0);
    read_en = 1'b1;
    write_all(2'd1, 2);
    build_expected(1, 48);
    drain_and_compare("slow", 20);

    // Overfill with no reads: the last five bits are dropped.
    make_bits(MAX_BITS + 5, 0);
    write_all(2'd0, 0);
    build_expected(0, MAX_BITS);
    drain_and_compare("full", MAX_BITS / 2 + 30);

    // Reset asserted mid-drain takes effect without waiting for a clock edge.
    make_bits(40, 0);
    write_all(2'd0, 0);
    read_en = 1'b1;
    for (int c = 0; c < 5; c++) step();
    #2 reset = 1'b0;
    #1;
    check("abort valid", data_out_valid, 1'b0);
    check("abort data", data_out, 2'b00);
    step();
    step();
    reset = 1'b1;
    got.delete();
    for (int c = 0; c < 10; c++) step();
    check("post-rst empty", got.size(), 0);
    read_en = 1'b0;
    step();

    make_bits(6, 0);
    write_all(2'd2, 0);
    build_expected(2, 6);
    drain_and_compare("post-rst r23", 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
